// File: rtl/multi_pulse_sync_pkg.sv
// Shared constants for multi_pulse_sync: edge-mode encodings, legal
// parameter ranges and the edge qualifier used by the per-channel detector.
package multi_pulse_sync_pkg;

   localparam logic [1:0] MODE_ANY  = 2'b00;
   localparam logic [1:0] MODE_RISE = 2'b01;
   localparam logic [1:0] MODE_FALL = 2'b10;

   localparam int unsigned CH_MIN    = 1;
   localparam int unsigned CH_MAX    = 32;
   localparam int unsigned SYNC_MIN  = 2;
   localparam int unsigned SYNC_MAX  = 4;
   localparam int unsigned CNT_W_MIN = 1;
   localparam int unsigned CNT_W_MAX = 8;

   // Qualify a level change; any unlisted mode (including 2'b11) means either edge.
   function automatic logic edge_qualify(input logic [1:0] mode,
                                         input logic       cur,
                                         input logic       prev);
      logic hit;
      case (mode)
         MODE_RISE: hit = cur & ~prev;
         MODE_FALL: hit = ~cur & prev;
         default:   hit = cur ^ prev;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchroniser; pure flop chain with no logic between stages.
module bit_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   (* async_reg = "true" *) logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift the raw input one stage deeper each cycle.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], din};
   end

   // Synchroniser chain register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/multi_pulse_sync.sv
// Multi-channel async event synchroniser with per-channel pending-event
// counters and valid/ready handoff. Optional sticky overflow flag is built
// when MULTI_PULSE_SYNC_OVF_EN is defined; otherwise evt_overflow reads 0.
module multi_pulse_sync
   import multi_pulse_sync_pkg::*;
#(
   parameter int unsigned CH          = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 3,
   parameter logic [1:0]  EDGE_MODE   = MODE_ANY
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CH-1:0] async_in,
   output logic [CH-1:0] evt_valid,
   input  logic [CH-1:0] evt_ready,
   output logic [CH-1:0] evt_overflow,
   input  logic [CH-1:0] ovf_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (CH < CH_MIN || CH > CH_MAX ||
       SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX ||
       CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_param
      $error("multi_pulse_sync: parameter outside legal range");
   end

   logic [CH-1:0]            sync_out;
   logic [CH-1:0]            hist_q, hist_d;
   logic [CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [CH-1:0]            valid_q, valid_d;
   logic [CH-1:0]            ovf_q, ovf_d;
   logic [CH-1:0]            detect, accept, sat_hit;

   // One synchroniser per channel.
   for (genvar i = 0; i < CH; i++) begin : g_sync
      bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk  (clk),
         .rst  (rst),
         .din  (async_in[i]),
         .dout (sync_out[i])
      );
   end

   // Edge detect, pending-count update and overflow tracking per channel.
   always_comb begin
      hist_d  = sync_out;
      cnt_d   = cnt_q;
      valid_d = '0;
      ovf_d   = '0;
      detect  = '0;
      accept  = '0;
      sat_hit = '0;
      for (int i = 0; i < int'(CH); i++) begin
         detect[i] = edge_qualify(EDGE_MODE, sync_out[i], hist_q[i]);
         accept[i] = valid_q[i] & evt_ready[i];
         if (detect[i] && !accept[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               sat_hit[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end else if (accept[i] && !detect[i]) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
         valid_d[i] = (cnt_d[i] != '0);
`ifdef MULTI_PULSE_SYNC_OVF_EN
         // A new saturation in the same cycle as a clear keeps the flag set.
         ovf_d[i] = (ovf_q[i] & ~ovf_clr[i]) | sat_hit[i];
`else
         ovf_d[i] = 1'b0;
`endif
      end
   end

`ifndef MULTI_PULSE_SYNC_OVF_EN
   // Overflow inputs are intentionally ignored in this build.
   logic ovf_in_unused;
   assign ovf_in_unused = ^{ovf_clr, sat_hit};
`endif

   // Channel state registers; reset discards all pending events at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q  <= '0;
         cnt_q   <= '0;
         valid_q <= '0;
         ovf_q   <= '0;
      end else begin
         hist_q  <= hist_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign evt_valid    = valid_q;
   assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_multi_pulse_sync.sv
// Bench for multi_pulse_sync: four instances (any/rise/2'b11 with CNT_W=2/fall)
// share one stimulus; an event-count model is compared every cycle.
module tb_multi_pulse_sync;
   import multi_pulse_sync_pkg::*;

   localparam int ND  = 4;
   localparam int NCH = 4;
   localparam int HN  = 4096;
`ifdef MULTI_PULSE_SYNC_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] a_in = 4'hF;
   logic [3:0] rdy  = 4'h0;
   logic [3:0] clr  = 4'h0;
   logic [3:0] vld [ND];
   logic [3:0] ovf [ND];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   multi_pulse_sync #(.CH(4), .SYNC_STAGES(2), .CNT_W(3), .EDGE_MODE(MODE_ANY)) u_any (
      .clk(clk), .rst(rst), .async_in(a_in), .evt_valid(vld[0]), .evt_ready(rdy),
      .evt_overflow(ovf[0]), .ovf_clr(clr));
   multi_pulse_sync #(.CH(4), .SYNC_STAGES(2), .CNT_W(3), .EDGE_MODE(MODE_RISE)) u_rise (
      .clk(clk), .rst(rst), .async_in(a_in), .evt_valid(vld[1]), .evt_ready(rdy),
      .evt_overflow(ovf[1]), .ovf_clr(clr));
   multi_pulse_sync #(.CH(4), .SYNC_STAGES(2), .CNT_W(2), .EDGE_MODE(2'b11)) u_sat (
      .clk(clk), .rst(rst), .async_in(a_in), .evt_valid(vld[2]), .evt_ready(rdy),
      .evt_overflow(ovf[2]), .ovf_clr(clr));
   multi_pulse_sync #(.CH(4), .SYNC_STAGES(2), .CNT_W(3), .EDGE_MODE(MODE_FALL)) u_fall (
      .clk(clk), .rst(rst), .async_in(a_in), .evt_valid(vld[3]), .evt_ready(rdy),
      .evt_overflow(ovf[3]), .ovf_clr(clr));

   // ---------------- model ----------------
   // 0 = either edge, 1 = rising only, 2 = falling only
   int m_kind [ND] = '{0, 1, 0, 2};
   int m_max  [ND] = '{7, 7, 3, 7};
   int m_cnt  [ND][NCH];
   bit m_ovf  [ND][NCH];
   logic [3:0] smp [HN];
   int n = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int d = 0; d < ND; d++)
         for (int c = 0; c < NCH; c++) begin
            m_cnt[d][c] = 0;
            m_ovf[d][c] = 1'b0;
         end
   endtask

   always @(posedge rst) model_clear();

   // Input level seen at edge n reaches the counter at edge n+2 (two sync stages).
   always @(posedge clk) begin
      smp[n % HN] = rst ? 4'h0 : a_in;
      if (rst) begin
         model_clear();
      end else if (n >= 3) begin
         for (int d = 0; d < ND; d++)
            for (int c = 0; c < NCH; c++) begin
               int cur, prev;
               bit ev, acc, sat;
               cur  = int'(smp[(n - 2) % HN][c]);
               prev = int'(smp[(n - 3) % HN][c]);
               ev   = (m_kind[d] == 0) ? (cur != prev) :
                      (m_kind[d] == 1) ? (cur > prev) : (cur < prev);
               acc  = rdy[c] && (m_cnt[d][c] > 0);
               sat  = 1'b0;
               if (ev && !acc) begin
                  if (m_cnt[d][c] == m_max[d]) sat = 1'b1;
                  else m_cnt[d][c] = m_cnt[d][c] + 1;
               end else if (acc && !ev) begin
                  m_cnt[d][c] = m_cnt[d][c] - 1;
               end
               if (OVF_EN) begin
                  if (sat) m_ovf[d][c] = 1'b1;
                  else if (clr[c]) m_ovf[d][c] = 1'b0;
               end
            end
      end
      n++;
   end

   // Every-cycle comparison of all instances against the model.
   always @(negedge clk) begin
      for (int d = 0; d < ND; d++) begin
         logic [3:0] ev, eo;
         for (int c = 0; c < NCH; c++) begin
            ev[c] = (m_cnt[d][c] != 0);
            eo[c] = m_ovf[d][c];
         end
         check($sformatf("cyc_valid_d%0d", d), 32'(vld[d]), 32'(ev));
         check($sformatf("cyc_ovf_d%0d", d), 32'(ovf[d]), 32'(eo));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_rdy(input logic [3:0] m);
      rdy = m;
      tick();
      rdy = 4'h0;
   endtask

   task automatic drain();
      rdy = 4'hF;
      repeat (10) tick();
      rdy = 4'h0;
      tick();
   endtask

   initial begin
      // Input high through reset release.
      repeat (4) tick();
      for (int d = 0; d < ND; d++) check($sformatf("rst_valid_d%0d", d), 32'(vld[d]), 32'h0);
      rst = 1'b0;
      repeat (3) tick();
      check("rel_any",  32'(vld[0]), 32'hF);
      check("rel_rise", 32'(vld[1]), 32'hF);
      check("rel_fall", 32'(vld[3]), 32'h0);
      tick();
      pulse_rdy(4'hF);
      check("rel_one_evt", 32'(vld[0]), 32'h0);
      a_in = 4'h0;
      repeat (4) tick();
      drain();

      // Latency and single accept on channel 0.
      a_in[0] = 1'b1;
      tick(); tick();
      check("lat_edge2", 32'(vld[0][0]), 32'h0);
      tick();
      check("lat_edge3", 32'(vld[0][0]), 32'h1);
      pulse_rdy(4'h1);
      check("accept_clr", 32'(vld[0][0]), 32'h0);
      a_in[0] = 1'b0;
      repeat (4) tick();
      drain();

      // Three toggles on channel 1, rising-only counts two.
      a_in[1] = 1'b1; tick(); tick();
      a_in[1] = 1'b0; tick(); tick();
      a_in[1] = 1'b1; repeat (5) tick();
      check("rise_model_cnt", 32'(m_cnt[1][1]), 32'd2);
      pulse_rdy(4'h2);
      check("rise_acc1", 32'(vld[1][1]), 32'h1);
      pulse_rdy(4'h2);
      check("rise_acc2", 32'(vld[1][1]), 32'h0);
      a_in[1] = 1'b0;
      repeat (4) tick();
      drain();

      // Detect and accept together at count 1 on channel 2.
      a_in[2] = 1'b1; repeat (4) tick();
      a_in[2] = 1'b0; tick(); tick();
      rdy[2] = 1'b1; tick(); rdy[2] = 1'b0;
      check("same_cyc_valid", 32'(vld[0][2]), 32'h1);
      check("same_cyc_model", 32'(m_cnt[0][2]), 32'd1);
      tick();
      drain();

      // Eight rising edges on channel 3 saturate the 2-bit counter.
      for (int k = 0; k < 8; k++) begin
         a_in[3] = 1'b1; tick(); tick();
         a_in[3] = 1'b0; tick(); tick();
      end
      repeat (4) tick();
      check("sat_model_cnt", 32'(m_cnt[2][3]), 32'd3);
      check("sat_valid", 32'(vld[2][3]), 32'h1);
      check("sat_ovf", 32'(ovf[2][3]), 32'(OVF_EN));
      clr[3] = 1'b1; tick(); clr[3] = 1'b0;
      check("ovf_clr", 32'(ovf[2][3]), 32'h0);
      check("clr_keeps_valid", 32'(vld[2][3]), 32'h1);
      // Saturating detect coinciding with clear: set wins.
      a_in[3] = 1'b1; tick(); tick();
      clr[3] = 1'b1; tick(); clr[3] = 1'b0;
      check("set_wins", 32'(ovf[2][3]), 32'(OVF_EN));
      clr[3] = 1'b1; tick(); clr[3] = 1'b0;
      check("ovf_clr2", 32'(ovf[2][3]), 32'h0);
      // Saturating detect with same-cycle accept: hold, no overflow.
      a_in[3] = 1'b0; tick(); tick();
      rdy[3] = 1'b1; tick(); rdy[3] = 1'b0;
      check("sat_acc_no_ovf", 32'(ovf[2][3]), 32'h0);
      tick();
      pulse_rdy(4'h8);
      pulse_rdy(4'h8);
      check("sat_drain2", 32'(vld[2][3]), 32'h1);
      pulse_rdy(4'h8);
      check("sat_drain3", 32'(vld[2][3]), 32'h0);
      drain();

      // Reset mid-burst clears outputs without a clock edge.
      a_in = 4'hF; tick(); tick();
      a_in = 4'h0; tick(); tick();
      a_in = 4'hF; tick(); tick();
      #1 rst = 1'b1;
      #1;
      for (int d = 0; d < ND; d++) begin
         check($sformatf("midrst_valid_d%0d", d), 32'(vld[d]), 32'h0);
         check($sformatf("midrst_ovf_d%0d", d), 32'(ovf[d]), 32'h0);
      end
      a_in = 4'h0;
      repeat (4) tick();
      rst = 1'b0;
      repeat (4) tick();

      // Mixed traffic, each input level held two cycles.
      for (int k = 0; k < 60; k++) begin
         a_in = 4'($urandom);
         rdy  = 4'($urandom);
         clr  = 4'($urandom_range(0, 15) & 4'h3);
         tick();
         rdy  = 4'($urandom);
         tick();
      end
      rdy = 4'h0;
      clr = 4'h0;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
